i2s_tx_sink: RTL and testbench

// - Output end of the effect chain: consumes the registered mono sample stream (audio + 1-cycle valid strobe)

---
 rtl/i2s_tx_sink.sv | 146 ++++++++++++++
 tb/tb_i2s_tx_sink.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_sink.sv
// I2S transmitter at the end of the effect chain: buffers one mono sample, sends it on both
// channels with internally generated BCLK/LRCLK, and paces upstream with sample_req.
module i2s_tx_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int DAC_WIDTH  = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] audio_in,
    output logic                  sample_req,
    output logic                  underrun,
    output logic                  overrun,
    output logic                  i2s_bclk,
    output logic                  i2s_lrclk,
    output logic                  i2s_sdata
);

    localparam int FRAME_W = 2 * SLOT_WIDTH;
    localparam int PAD_W   = SLOT_WIDTH - DAC_WIDTH;
    localparam int DIV_W   = $clog2(BCLK_DIV);
    localparam int P_W     = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [P_W-1:0]   P_LAST   = P_W'(FRAME_W - 1);

    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic                 bclk_q, bclk_d;
    logic [P_W-1:0]       p_q, p_d;
    logic                 lrclk_q, lrclk_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [DAC_WIDTH-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DAC_WIDTH-1:0] last_q, last_d;
    logic                 sample_req_q, sample_req_d;
    logic                 underrun_q, underrun_d;
    logic                 overrun_q, overrun_d;

    logic                  fall;
    logic                  load;
    logic [DAC_WIDTH-1:0]  load_sample;
    logic [SLOT_WIDTH-1:0] slot_word;

    // Low-order input bits below the DAC resolution are intentionally truncated.
    generate
        if (DATA_WIDTH > DAC_WIDTH) begin : g_trunc
            logic unused_audio_lsbs;
            assign unused_audio_lsbs = ^audio_in[DATA_WIDTH-DAC_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        div_cnt_d    = div_cnt_q;
        bclk_d       = bclk_q;
        p_d          = p_q;
        lrclk_d      = lrclk_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        last_d       = last_q;
        sample_req_d = 1'b0;
        underrun_d   = 1'b0;
        overrun_d    = 1'b0;
        fall         = 1'b0;
        load         = 1'b0;
        load_sample  = last_q;
        slot_word    = '0;

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
            fall      = bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        // NOTE: blocking '=' here so p_d is usable immediately below; flops use '<=' only.
        if (fall) begin
            p_d     = (p_q == P_LAST) ? '0 : p_q + P_W'(1);
            lrclk_d = (p_d >= P_W'(SLOT_WIDTH));
            load    = (p_d == P_W'(1));
        end

        if (load) begin
            if (hold_full_q) begin
                load_sample = hold_q;
                last_d      = hold_q;
                hold_full_d = 1'b0;
            end else begin
                underrun_d  = 1'b1;
            end
            sample_req_d = 1'b1;
            slot_word    = SLOT_WIDTH'(load_sample) << PAD_W;
            shift_d      = {slot_word, slot_word};
        end else if (fall) begin
            shift_d = shift_q << 1;
        end

        // Capture after the load decision so a same-cycle strobe lands in the next frame.
        if (sample_valid) begin
            hold_d      = audio_in[DATA_WIDTH-1 -: DAC_WIDTH];
            hold_full_d = 1'b1;
            overrun_d   = hold_full_q && !load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: hold/last are cleared too, so a post-reset underrun replays silence.
            div_cnt_q    <= '0;
            bclk_q       <= 1'b0;
            p_q          <= '0;
            lrclk_q      <= 1'b0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            last_q       <= '0;
            sample_req_q <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bclk_q       <= bclk_d;
            p_q          <= p_d;
            lrclk_q      <= lrclk_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            last_q       <= last_d;
            sample_req_q <= sample_req_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
        end
    end

    assign sample_req = sample_req_q;
    assign underrun   = underrun_q;
    assign overrun    = overrun_q;
    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sdata  = shift_q[FRAME_W-1];

endmodule

// File: tb/tb_i2s_tx_sink.sv
// Directed bench for i2s_tx_sink at default parameters: reset, framing, buffering, flags.
module tb_i2s_tx_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [31:0] audio_in;
    logic        sample_req, underrun, overrun;
    logic        i2s_bclk, i2s_lrclk, i2s_sdata;

    int checks   = 0;
    int failures = 0;
    int n_req, n_und, n_ovr;
    int waited;

    logic [63:0] word, lr;

    localparam logic [63:0] LR_MASK = 64'h0000_0001_FFFF_FFFE;

    i2s_tx_sink dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .audio_in     (audio_in),
        .sample_req   (sample_req),
        .underrun     (underrun),
        .overrun      (overrun),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sample_req) n_req++;
        if (underrun)   n_und++;
        if (overrun)    n_ovr++;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        n_req = 0;
        n_und = 0;
        n_ovr = 0;
    endtask

    task automatic pulse_sample(input logic [31:0] s);
        sample_valid = 1'b1;
        audio_in     = s;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_req(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sample_req && n < budget);
        check("wait_req_timeout", {63'd0, sample_req}, 64'd1);
    endtask

    // Starts on a load cycle; samples one bit per fall event and ends on the next load cycle.
    task automatic capture_frame(output logic [63:0] w, output logic [63:0] l);
        for (int i = 0; i < 64; i++) begin
            w[63-i] = i2s_sdata;
            l[63-i] = i2s_lrclk;
            step(8);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {58'd0, i2s_bclk, i2s_lrclk, i2s_sdata, sample_req, underrun, overrun}, 64'd0);
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        audio_in     = '0;
        clear_counts();

        step(5);
        check_all_zero("reset_outputs");

        reset        = 1'b0;
        sample_valid = 1'b1;
        audio_in     = 32'h1234_5678;
        tick();
        sample_valid = 1'b0;
        step(2);
        check("bclk_low_c3", {63'd0, i2s_bclk}, 64'd0);
        tick();
        check("bclk_rise_c4", {63'd0, i2s_bclk}, 64'd1);
        step(3);
        check("bclk_high_c7", {63'd0, i2s_bclk}, 64'd1);
        tick();
        check("bclk_fall_c8", {63'd0, i2s_bclk}, 64'd0);
        check("first_load_flags", {61'd0, sample_req, underrun, overrun}, 64'b100);
        check("first_left_msb_lr", {62'd0, i2s_lrclk, i2s_sdata}, 64'b00);

        clear_counts();
        capture_frame(word, lr);
        check("frame1_data", word, {24'h123456, 8'h00, 24'h123456, 8'h00});
        check("frame1_lrclk", lr, LR_MASK);
        check("frame1_counts", {n_req[15:0], n_und[15:0], n_ovr[15:0]}, {16'd1, 16'd1, 16'd0});

        clear_counts();
        capture_frame(word, lr);
        check("frame2_repeat", word, {24'h123456, 8'h00, 24'h123456, 8'h00});
        check("frame2_counts", {n_req[15:0], n_und[15:0], n_ovr[15:0]}, {16'd1, 16'd1, 16'd0});

        clear_counts();
        step(10);
        pulse_sample(32'hAAAA_AA00);
        check("no_ovr_first", {63'd0, overrun}, 64'd0);
        step(10);
        pulse_sample(32'h8000_0000);
        check("ovr_pulse", {63'd0, overrun}, 64'd1);
        wait_req(600, waited);
        check("req_period", 64'(waited), 64'd490);
        check("ovr_counts", {n_req[15:0], n_und[15:0], n_ovr[15:0]}, {16'd1, 16'd0, 16'd1});
        check("neg_msb", {63'd0, i2s_sdata}, 64'd1);
        clear_counts();
        capture_frame(word, lr);
        check("frame_neg", word, {24'h800000, 8'h00, 24'h800000, 8'h00});
        check("frame_neg_counts", {n_req[15:0], n_und[15:0], n_ovr[15:0]}, {16'd1, 16'd1, 16'd0});

        clear_counts();
        step(100);
        pulse_sample(32'hC0FF_EE11);
        step(410);
        sample_valid = 1'b1;
        audio_in     = 32'h3456_789A;
        tick();
        sample_valid = 1'b0;
        check("simul_load_flags", {61'd0, sample_req, underrun, overrun}, 64'b100);
        check("simul_counts", {n_req[15:0], n_und[15:0], n_ovr[15:0]}, {16'd1, 16'd0, 16'd0});
        check("simul_msb", {63'd0, i2s_sdata}, 64'd1);
        clear_counts();
        capture_frame(word, lr);
        check("frame_prior_hold", word, {24'hC0FFEE, 8'h00, 24'hC0FFEE, 8'h00});
        check("frame_prior_counts", {n_req[15:0], n_und[15:0], n_ovr[15:0]}, {16'd1, 16'd0, 16'd0});
        clear_counts();
        capture_frame(word, lr);
        check("frame_new_sample", word, {24'h345678, 8'h00, 24'h345678, 8'h00});
        check("frame_new_lrclk", lr, LR_MASK);

        step(5);
        pulse_sample(32'h7FFF_FFFF);
        step(50);
        reset = 1'b1;
        tick();
        check_all_zero("midframe_reset");
        reset = 1'b0;
        clear_counts();
        wait_req(600, waited);
        check("post_reset_latency", 64'(waited), 64'd8);
        check("post_reset_underrun", {62'd0, underrun, overrun}, 64'b10);
        clear_counts();
        capture_frame(word, lr);
        check("post_reset_frame", word, 64'd0);
        check("post_reset_counts", {n_req[15:0], n_und[15:0], n_ovr[15:0]}, {16'd1, 16'd1, 16'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
